// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the SIPO deserializer.
// Rev 1.0 -- initial release.
`default_nettype none

package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // XOR of data bits and parity bit for a correctly formed even-parity frame.
  localparam logic EVEN_PARITY_POL = 1'b0;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: serial shift register, bit counter and frame-complete strobe.
// Rev 1.0 -- initial release. Optional feature: SIPO_PARITY_EN (trailing even-parity bit).
`default_nettype none

module sipo_shift_core import sipo_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
`ifdef SIPO_PARITY_EN
  output logic                          frame_parity_err,
`endif
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic                          serial_in,
  output logic [count_width(WIDTH)-1:0] bit_count,
  output logic                          frame_done,
  output logic [WIDTH-1:0]              frame_word
);

  localparam int CW = count_width(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {sreg[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign shifted = {serial_in, sreg[WIDTH-1:1]};
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;

  logic parity_acc;

  // The parity bit edge never shifts, so sreg already holds the whole data word.
  assign frame_word       = sreg;
  assign frame_parity_err = parity_acc ^ serial_in ^ EVEN_PARITY_POL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_acc <= 1'b0;
    end else if (clear || frame_done) begin
      parity_acc <= 1'b0;
    end else if (in_valid) begin
      parity_acc <= parity_acc ^ serial_in;
    end
  end
`else
  localparam int FRAME_LEN = WIDTH;

  assign frame_word = shifted;
`endif

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  assign frame_done = in_valid && (bit_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg      <= '0;
      bit_count <= '0;
    end else if (clear || frame_done) begin
      sreg      <= '0;
      bit_count <= '0;
    end else if (in_valid) begin
      sreg      <= shifted;
      bit_count <= bit_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out with valid/ready output, sticky overrun and parity check.
// Rev 1.0 -- initial release. Optional feature: SIPO_PARITY_EN (trailing even-parity bit).
`default_nettype none

module sipo_deserializer import sipo_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          in_valid,
  input  logic                          clear,
  output logic [WIDTH-1:0]              parallel_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [count_width(WIDTH)-1:0] bit_count,
  output logic                          overrun,
  output logic                          parity_err
);

  logic             frame_done;
  logic [WIDTH-1:0] frame_word;
  logic             load;

`ifdef SIPO_PARITY_EN
  logic frame_parity_err;
`endif

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
`ifdef SIPO_PARITY_EN
    .frame_parity_err (frame_parity_err),
`endif
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .serial_in  (serial_in),
    .bit_count  (bit_count),
    .frame_done (frame_done),
    .frame_word (frame_word)
  );

  // A new word may land only when the holding register is empty or being drained this edge.
  assign load = frame_done && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      parallel_out <= frame_word;
      out_valid    <= 1'b1;
    end else if (frame_done) begin
      overrun      <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (clear) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= frame_parity_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed self-checking bench, WIDTH=4, MSB-first and LSB-first instances.
// Rev 1.0 -- initial release. Honours SIPO_PARITY_EN when defined.
`default_nettype none

module tb_sipo_deserializer;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             serial_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;

  logic [WIDTH-1:0] m_pout, l_pout;
  logic             m_ovalid, l_ovalid;
  logic [CW-1:0]    m_cnt, l_cnt;
  logic             m_ovr, l_ovr;
  logic             m_perr, l_perr;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid), .clear(clear),
    .parallel_out(m_pout), .out_valid(m_ovalid), .out_ready(out_ready),
    .bit_count(m_cnt), .overrun(m_ovr), .parity_err(m_perr)
  );

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid), .clear(clear),
    .parallel_out(l_pout), .out_valid(l_ovalid), .out_ready(out_ready),
    .bit_count(l_cnt), .overrun(l_ovr), .parity_err(l_perr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Word bits are sent in written order: w[3] first.
  task automatic send_head(input logic [3:0] w);
    send_bit(w[3]);
    send_bit(w[2]);
    send_bit(w[1]);
  endtask

  // rdy is applied only for the frame's final edge.
  task automatic send_tail(input logic [3:0] w, input logic p, input logic rdy);
`ifdef SIPO_PARITY_EN
    send_bit(w[0]);
    out_ready = rdy;
    send_bit(p);
`else
    out_ready = rdy;
    send_bit(w[0]);
    if (p) ; // parity bit not transmitted in this build
`endif
  endtask

  task automatic send_frame(input logic [3:0] w, input logic p);
    send_head(w);
    send_tail(w, p, out_ready);
  endtask

  initial begin
    idle(2);
    check("rst_pout",   m_pout,   4'h0);
    check("rst_ovalid", m_ovalid, 1'b0);
    check("rst_cnt",    m_cnt,    3'd0);
    check("rst_ovr",    m_ovr,    1'b0);
    check("rst_perr",   m_perr,   1'b0);
    rst = 1'b1;
    idle(1);

    // First frame, ordering in both instances.
    send_head(4'b1011);
    check("partial_ovalid", m_ovalid, 1'b0);
    check("partial_cnt",    m_cnt,    3'd3);
    send_tail(4'b1011, 1'b1, 1'b0);
    check("msb_ovalid", m_ovalid, 1'b1);
    check("msb_pout",   m_pout,   4'b1011);
    check("lsb_pout",   l_pout,   4'b1101);
    check("lsb_ovalid", l_ovalid, 1'b1);
    check("done_cnt",   m_cnt,    3'd0);
    check("no_ovr",     m_ovr,    1'b0);

    // Overrun with the consumer stalled.
    send_frame(4'b0110, 1'b0);
    check("ovr_pout",   m_pout,   4'b1011);
    check("ovr_flag",   m_ovr,    1'b1);
    check("ovr_ovalid", m_ovalid, 1'b1);
    idle(2);
    check("ovr_sticky", m_ovr,    1'b1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clr_ovalid", m_ovalid, 1'b0);
    check("clr_ovr",    m_ovr,    1'b0);
    check("clr_cnt",    m_cnt,    3'd0);

    // Back-to-back frames with out_ready held high.
    out_ready = 1'b1;
    send_frame(4'b1011, 1'b1);
    check("b2b1_ovalid", m_ovalid, 1'b1);
    check("b2b1_pout",   m_pout,   4'b1011);
    send_head(4'b0110);
    check("accept_ovalid", m_ovalid, 1'b0);
    send_tail(4'b0110, 1'b0, 1'b1);
    check("b2b2_ovalid", m_ovalid, 1'b1);
    check("b2b2_pout",   m_pout,   4'b0110);
    check("b2b_ovr",     m_ovr,    1'b0);

    // Frame completes on the same edge as the accept.
    out_ready = 1'b0;
    send_head(4'b1011);
    check("hold_pout",   m_pout,   4'b0110);
    check("hold_ovalid", m_ovalid, 1'b1);
    send_tail(4'b1011, 1'b1, 1'b1);
    check("sim_ovalid", m_ovalid, 1'b1);
    check("sim_pout",   m_pout,   4'b1011);
    check("sim_ovr",    m_ovr,    1'b0);

    // in_valid low holds a partial frame; reset discards it.
    out_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    idle(3);
    check("hold_cnt", m_cnt, 3'd2);
    rst = 1'b0;
    #1;
    check("arst_cnt",    m_cnt,    3'd0);
    check("arst_ovalid", m_ovalid, 1'b0);
    check("arst_pout",   m_pout,   4'h0);
    idle(1);
    rst = 1'b1;
    send_frame(4'b0110, 1'b0);
    check("post_rst_pout",   m_pout,   4'b0110);
    check("post_rst_ovalid", m_ovalid, 1'b1);
    check("post_rst_cnt",    m_cnt,    3'd0);
    check("post_rst_lsb",    l_pout,   4'b0110);

    // Parity: 1011 has odd weight, so p=1 is good and p=0 is an error.
    out_ready = 1'b1;
    send_frame(4'b1011, 1'b1);
    check("par_good_ovalid", m_ovalid, 1'b1);
    check("par_good_perr",   m_perr,   1'b0);
    send_frame(4'b1011, 1'b0);
    check("par_bad_ovalid", m_ovalid, 1'b1);
    check("par_bad_pout",   m_pout,   4'b1011);
`ifdef SIPO_PARITY_EN
    check("par_bad_perr",   m_perr,   1'b1);
`else
    check("par_tied_perr",  m_perr,   1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
